// File: rtl/sim_finish_responder.sv
// sim_finish_responder
// Design-side end of the simulation finish protocol. A finish request is
// accepted once the post-reset holdoff has elapsed; the block then drains
// outstanding transactions (bounded by DRAIN_TIMEOUT, 0 = unbounded), holds
// two flush cycles so in-flight indications reach the host, and finally
// raises a sticky finish with the latched exit code. It also provides the
// free-running cycle counter used by the simulation top.
//
// Optional build macro: SIM_FINISH_TRACE_EN
//   Defined   -> simulation-only trace of every state transition.
//   Undefined -> no display statements; logic and ports are identical.
//
// state    | meaning
// ---------+------------------------------------------------------------
// HOLDOFF  | reset window; requests are not accepted
// IDLE     | req_ready=1, waiting for a finish request
// DRAIN    | waiting for outstanding count to reach 0 (or timeout)
// FLUSH    | two cycles for in-flight indications to reach the host
// DONE     | finish=1; terminal until RST

module sim_finish_responder #(
    parameter int HOLDOFF_CYCLES = 20,
    parameter int DRAIN_TIMEOUT  = 1024,
    parameter int OUT_W          = 8,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic [7:0]       req_code,
    output logic             req_ready,
    input  logic             txn_issue,
    input  logic             txn_done,
    output logic [OUT_W-1:0] outstanding,
    output logic             finish,
    output logic [7:0]       finish_code,
    output logic             timeout_flag,
    output logic             count_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_HOLDOFF = 3'd0,
        S_IDLE    = 3'd1,
        S_DRAIN   = 3'd2,
        S_FLUSH   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // HOLDOFF_CYCLES of 0 collapses to a last value of 0, so HOLDOFF is left
    // after the first cycle, same as HOLDOFF_CYCLES=1.
    localparam logic [CNT_W-1:0] HOLDOFF_LAST =
        (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] DRAIN_LAST =
        (DRAIN_TIMEOUT > 0) ? CNT_W'(DRAIN_TIMEOUT - 1) : '0;
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] holdoff_cnt;
    logic [CNT_W-1:0] drain_cnt;
    logic             flush_cnt;
    logic [OUT_W-1:0] out_next;
    logic             out_err;

    assign req_ready = (state == S_IDLE);

    // Next outstanding value; saturates at both ends and flags the attempt
    always_comb begin
        out_next = outstanding;
        out_err  = 1'b0;
        if (state != S_DONE) begin
            if (txn_issue && !txn_done) begin
                if (outstanding == OUT_MAX) begin
                    out_err = 1'b1;
                end else begin
                    out_next = outstanding + 1'b1;
                end
            end else if (txn_done && !txn_issue) begin
                if (outstanding == '0) begin
                    out_err = 1'b1;
                end else begin
                    out_next = outstanding - 1'b1;
                end
            end
        end
    end

    // Free-running cycle counter, outstanding counter and sticky error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_count <= '0;
            outstanding <= '0;
            count_err   <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            outstanding <= out_next;
            if (out_err) begin
                count_err <= 1'b1;
            end
        end
    end

    // Finish sequencing FSM with registered busy/finish/code/timeout outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_HOLDOFF;
            holdoff_cnt  <= '0;
            drain_cnt    <= '0;
            flush_cnt    <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
            finish_code  <= 8'h00;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_HOLDOFF: begin
                    if (holdoff_cnt == HOLDOFF_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        holdoff_cnt <= holdoff_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        finish_code <= req_code;
                        drain_cnt   <= '0;
                        busy        <= 1'b1;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Drain completion takes priority over a coincident timeout
                    if (out_next == '0) begin
                        flush_cnt <= 1'b0;
                        state     <= S_FLUSH;
                    end else if ((DRAIN_TIMEOUT != 0) && (drain_cnt == DRAIN_LAST)) begin
                        timeout_flag <= 1'b1;
                        flush_cnt    <= 1'b0;
                        state        <= S_FLUSH;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt) begin
                        busy   <= 1'b0;
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_HOLDOFF;
                end
            endcase
        end
    end

`ifdef SIM_FINISH_TRACE_EN
    state_t trace_prev;

    // Report each state change; entry to DONE also reports the outcome
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            trace_prev <= S_HOLDOFF;
        end else begin
            trace_prev <= state;
            if (state != trace_prev) begin
                if (state == S_DONE) begin
                    $display("sim_finish_responder: cycle %0d state %s outstanding %0d finish_code %02h timeout_flag %0d",
                             cycle_count, state.name(), outstanding, finish_code, timeout_flag);
                end else begin
                    $display("sim_finish_responder: cycle %0d state %s outstanding %0d",
                             cycle_count, state.name(), outstanding);
                end
            end
        end
    end
`endif

endmodule
